ika2151_timer: RTL

Timer A/B block of the IKA2151 core. It drives the register block's i_TIMERA_FLAG, i_TIMERB_FLAG and i_TIMERA_OVFL inputs, which are currently unconnected in the top level.
- Consumes CLKA1/CLKA2/CLKB and TIMERCTRL from the register block, plus i_CYCLE_31 from the timing generator.
- Generates the YM2151 timer A (10-bit) and timer B (8-bit) periods, status flags, IRQ and the CSM overflow pulse.

---
 rtl/ika2151_timer.sv | 116 +++++++++++
 1 files changed

// File: rtl/ika2151_timer.sv
// YM2151 timer A (10-bit) / timer B (8-bit) with sticky flags, IRQ and CSM overflow pulse.
// State advances only on enabled EMUCLK edges; flags and OVFL are registered, IRQ is combinational.
module ika2151_timer (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic [7:0] i_CLKA1,
  input  logic [1:0] i_CLKA2,
  input  logic [7:0] i_CLKB,
  input  logic [5:0] i_TIMERCTRL,
  input  logic       i_TIMERCTRL_WR,
  output logic       o_TIMERA_FLAG,
  output logic       o_TIMERB_FLAG,
  output logic       o_TIMERA_OVFL,
  output logic       o_IRQ_n
);

  logic       en, tick, tick_b;
  logic       load_a, load_b, irqen_a, irqen_b, frst_a, frst_b;
  logic       ovf_a, ovf_b;
  logic [9:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;
  logic [3:0] presc_q, presc_d;
  logic       load_a_prev_q, load_a_prev_d;
  logic       load_b_prev_q, load_b_prev_d;
  logic       flag_a_q, flag_a_d;
  logic       flag_b_q, flag_b_d;
  logic       ovfl_q, ovfl_d;

  assign en      = ~i_phi1_NCEN_n;
  assign tick    = en & i_CYCLE_31;
  assign tick_b  = tick & (presc_q == 4'd15);
  assign load_a  = i_TIMERCTRL[0];
  assign load_b  = i_TIMERCTRL[1];
  assign irqen_a = i_TIMERCTRL[2];
  assign irqen_b = i_TIMERCTRL[3];
  assign frst_a  = i_TIMERCTRL[4];
  assign frst_b  = i_TIMERCTRL[5];

  always_comb begin
    cnt_a_d       = cnt_a_q;
    cnt_b_d       = cnt_b_q;
    presc_d       = presc_q;
    load_a_prev_d = load_a_prev_q;
    load_b_prev_d = load_b_prev_q;
    flag_a_d      = flag_a_q;
    flag_b_d      = flag_b_q;
    ovfl_d        = ovfl_q;
    ovf_a         = 1'b0;
    ovf_b         = 1'b0;
    if (en) begin
      if (tick) presc_d = presc_q + 4'd1;
      load_a_prev_d = load_a;
      load_b_prev_d = load_b;

      // A load edge takes priority over any tick in the same cycle.
      if (load_a & ~load_a_prev_q) begin
        cnt_a_d = {i_CLKA1, i_CLKA2};
      end else if (load_a & tick) begin
        if (cnt_a_q == 10'h3FF) begin
          ovf_a   = 1'b1;
          cnt_a_d = {i_CLKA1, i_CLKA2};
        end else begin
          cnt_a_d = cnt_a_q + 10'd1;
        end
      end

      if (load_b & ~load_b_prev_q) begin
        cnt_b_d = i_CLKB;
      end else if (load_b & tick_b) begin
        if (cnt_b_q == 8'hFF) begin
          ovf_b   = 1'b1;
          cnt_b_d = i_CLKB;
        end else begin
          cnt_b_d = cnt_b_q + 8'd1;
        end
      end

      ovfl_d = ovf_a;
      // Set beats clear so an overflow coinciding with a flag reset is not lost.
      if (ovf_a & irqen_a)                  flag_a_d = 1'b1;
      else if (i_TIMERCTRL_WR & frst_a)     flag_a_d = 1'b0;
      if (ovf_b & irqen_b)                  flag_b_d = 1'b1;
      else if (i_TIMERCTRL_WR & frst_b)     flag_b_d = 1'b0;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cnt_a_q       <= 10'd0;
      cnt_b_q       <= 8'd0;
      presc_q       <= 4'd0;
      load_a_prev_q <= 1'b0;
      load_b_prev_q <= 1'b0;
      flag_a_q      <= 1'b0;
      flag_b_q      <= 1'b0;
      ovfl_q        <= 1'b0;
    end else begin
      cnt_a_q       <= cnt_a_d;
      cnt_b_q       <= cnt_b_d;
      presc_q       <= presc_d;
      load_a_prev_q <= load_a_prev_d;
      load_b_prev_q <= load_b_prev_d;
      flag_a_q      <= flag_a_d;
      flag_b_q      <= flag_b_d;
      ovfl_q        <= ovfl_d;
    end
  end

  assign o_TIMERA_FLAG = flag_a_q;
  assign o_TIMERB_FLAG = flag_b_q;
  assign o_TIMERA_OVFL = ovfl_q;
  assign o_IRQ_n       = ~(flag_a_q | flag_b_q);

endmodule
